// File: rtl/chess_clock_time_ctrl.sv
// Chess clock time-control sequencer: loads both budgets, runs a one-second prescaler for the
// active player, applies Fischer increments on direct hand-over and flags exhausted budgets.
module chess_clock_time_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned TIME_W   = 12,
  parameter int unsigned INC_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_restart,
  input  logic              i_a_stop,
  input  logic              i_b_stop,
  input  logic [TIME_W-1:0] i_cfg_time,
  input  logic [INC_W-1:0]  i_cfg_inc,
  output logic [TIME_W-1:0] o_a_time,
  output logic [TIME_W-1:0] o_b_time,
  output logic              o_a_zero,
  output logic              o_b_zero,
  output logic              o_tick
);

  localparam int unsigned    PS_W   = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_WAIT, S_RUN_A, S_RUN_B, S_PAUSED, S_EXPIRED
  } state_e;

  typedef enum logic [1:0] {RUN_NONE, RUN_A, RUN_B} run_e;

  state_e            state_q, state_d;
  run_e              prev_run_q, prev_run_d;
  run_e              run;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [INC_W-1:0]  inc_q, inc_d;
  logic [TIME_W-1:0] a_time_q, a_time_d, b_time_q, b_time_d;
  logic              a_zero_q, a_zero_d, b_zero_q, b_zero_d;
  logic              tick_q, tick_d;

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t,
                                                input logic [INC_W-1:0]  inc);
    logic [TIME_W:0] sum;
    sum = {1'b0, t} + (TIME_W+1)'(inc);
    return sum[TIME_W] ? '1 : sum[TIME_W-1:0];
  endfunction

  always_comb begin
    if (!i_a_stop && i_b_stop)      run = RUN_A;
    else if (i_a_stop && !i_b_stop) run = RUN_B;
    else                            run = RUN_NONE;
  end

  always_comb begin
    state_d    = state_q;
    prev_run_d = prev_run_q;
    presc_d    = presc_q;
    inc_d      = inc_q;
    a_time_d   = a_time_q;
    b_time_d   = b_time_q;
    a_zero_d   = a_zero_q;
    b_zero_d   = b_zero_q;
    tick_d     = 1'b0;

    if (i_restart || state_q == S_LOAD) begin
      a_time_d   = i_cfg_time;
      b_time_d   = i_cfg_time;
      inc_d      = i_cfg_inc;
      a_zero_d   = 1'b0;
      b_zero_d   = 1'b0;
      presc_d    = '0;
      prev_run_d = RUN_NONE;
      state_d    = i_restart ? S_LOAD : S_WAIT;
    end else begin
      case (state_q)
        S_WAIT, S_PAUSED: begin
          if (run == RUN_A) begin
            state_d    = S_RUN_A;
            prev_run_d = RUN_A;
          end else if (run == RUN_B) begin
            state_d    = S_RUN_B;
            prev_run_d = RUN_B;
          end
        end

        // An empty budget on entry expires without a tick; otherwise the last tick expires it.
        S_RUN_A: begin
          if (a_time_q == '0) begin
            a_zero_d = 1'b1;
            presc_d  = '0;
            state_d  = S_EXPIRED;
          end else if (run == RUN_A) begin
            if (presc_q == PS_MAX) begin
              presc_d  = '0;
              tick_d   = 1'b1;
              a_time_d = a_time_q - TIME_W'(1);
              if (a_time_q == TIME_W'(1)) begin
                a_zero_d = 1'b1;
                state_d  = S_EXPIRED;
              end
            end else begin
              presc_d = presc_q + PS_W'(1);
            end
          end else if (run == RUN_B) begin
            presc_d = '0;
            if (prev_run_q == RUN_A && !a_zero_q) a_time_d = sat_add(a_time_q, inc_q);
            prev_run_d = RUN_B;
            state_d    = S_RUN_B;
          end else begin
            presc_d    = '0;
            prev_run_d = RUN_NONE;
            state_d    = S_PAUSED;
          end
        end

        S_RUN_B: begin
          if (b_time_q == '0) begin
            b_zero_d = 1'b1;
            presc_d  = '0;
            state_d  = S_EXPIRED;
          end else if (run == RUN_B) begin
            if (presc_q == PS_MAX) begin
              presc_d  = '0;
              tick_d   = 1'b1;
              b_time_d = b_time_q - TIME_W'(1);
              if (b_time_q == TIME_W'(1)) begin
                b_zero_d = 1'b1;
                state_d  = S_EXPIRED;
              end
            end else begin
              presc_d = presc_q + PS_W'(1);
            end
          end else if (run == RUN_A) begin
            presc_d = '0;
            if (prev_run_q == RUN_B && !b_zero_q) b_time_d = sat_add(b_time_q, inc_q);
            prev_run_d = RUN_A;
            state_d    = S_RUN_A;
          end else begin
            presc_d    = '0;
            prev_run_d = RUN_NONE;
            state_d    = S_PAUSED;
          end
        end

        S_EXPIRED: ;

        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_LOAD;
      prev_run_q <= RUN_NONE;
      presc_q    <= '0;
      inc_q      <= '0;
      a_time_q   <= '0;
      b_time_q   <= '0;
      a_zero_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_run_q <= prev_run_d;
      presc_q    <= presc_d;
      inc_q      <= inc_d;
      a_time_q   <= a_time_d;
      b_time_q   <= b_time_d;
      a_zero_q   <= a_zero_d;
      b_zero_q   <= b_zero_d;
      tick_q     <= tick_d;
    end
  end

  assign o_a_time = a_time_q;
  assign o_b_time = b_time_q;
  assign o_a_zero = a_zero_q;
  assign o_b_zero = b_zero_q;
  assign o_tick   = tick_q;

endmodule

// File: tb/tb_chess_clock_time_ctrl.sv
// Directed bench for chess_clock_time_ctrl with a 4-cycle tick, 8-bit times and 4-bit increment.
module tb_chess_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst, restart, a_stop, b_stop;
  logic [7:0] cfg_time, a_time, b_time;
  logic [3:0] cfg_inc;
  logic       a_zero, b_zero, tick;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  chess_clock_time_ctrl #(.TICK_DIV(4), .TIME_W(8), .INC_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_restart(restart), .i_a_stop(a_stop), .i_b_stop(b_stop),
    .i_cfg_time(cfg_time), .i_cfg_inc(cfg_inc), .o_a_time(a_time), .o_b_time(b_time),
    .o_a_zero(a_zero), .o_b_zero(b_zero), .o_tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reload(input logic [7:0] t);
    cfg_time = t;
    a_stop = 1'b1; b_stop = 1'b1;
    restart = 1'b1; step(1);
    restart = 1'b0; step(1);
  endtask

  initial begin
    rst = 1'b1; restart = 1'b1; a_stop = 1'b1; b_stop = 1'b1;
    cfg_time = 8'd3; cfg_inc = 4'd2;
    step(2);
    check("rst_a", a_time, 0); check("rst_b", b_time, 0);
    check("rst_zero", {a_zero, b_zero}, 0); check("rst_tick", tick, 0);
    rst = 1'b0; step(2);
    check("load_a", a_time, 3); check("load_b", b_time, 3);
    check("load_zero", {a_zero, b_zero}, 0); check("load_tick", tick, 0);
    restart = 1'b0; step(1);

    // A runs: enter RUN_A, then ticks every 4 cycles
    a_stop = 1'b0; step(1);
    step(3); check("a_pre_tick", a_time, 3); check("a_pre_tick_t", tick, 0);
    step(1); check("a_tick1", a_time, 2); check("a_tick1_t", tick, 1);
    step(4); check("a_tick2", a_time, 1); check("a_tick2_b", b_time, 3);

    a_stop = 1'b1; b_stop = 1'b0; step(1);
    check("sw_ab_a", a_time, 3); check("sw_ab_b", b_time, 3); check("sw_ab_tick", tick, 0);
    step(4); check("b_tick1", b_time, 2); check("b_tick1_a", a_time, 3);

    a_stop = 1'b0; b_stop = 1'b1; step(1);
    check("sw_ba_b", b_time, 4); check("sw_ba_a", a_time, 3);
    step(11); check("a_run11", a_time, 1); check("a_run11_z", a_zero, 0);
    step(1); check("a_exp", a_time, 0); check("a_exp_z", a_zero, 1); check("a_exp_t", tick, 1);
    step(5); check("exp_hold_a", a_time, 0); check("exp_hold_t", tick, 0);
    a_stop = 1'b1; b_stop = 1'b0; step(1);
    a_stop = 1'b0; b_stop = 1'b1; step(5);
    check("exp_noinc_a", a_time, 0); check("exp_b", b_time, 4); check("exp_bz", b_zero, 0);

    reload(8'd3);
    check("reload_a", a_time, 3); check("reload_az", a_zero, 0);
    a_stop = 1'b0; step(1); step(2);
    a_stop = 1'b1; step(5);
    a_stop = 1'b0; step(1); check("resume_a", a_time, 3);
    step(3); check("resume_pre", a_time, 3); check("resume_pre_t", tick, 0);
    step(1); check("resume_tick", a_time, 2); check("resume_b", b_time, 3);

    reload(8'd255);
    a_stop = 1'b0; step(1); step(4); check("sat_pre", a_time, 254);
    a_stop = 1'b1; b_stop = 1'b0; step(1);
    check("sat_a", a_time, 255); check("sat_b", b_time, 255);

    step(2); cfg_time = 8'd3; restart = 1'b1; step(1);
    check("rs_mid_a", a_time, 3); check("rs_mid_b", b_time, 3);
    check("rs_mid_z", {a_zero, b_zero}, 0);

    restart = 1'b0; a_stop = 1'b0; b_stop = 1'b0; step(10);
    check("both_low_a", a_time, 3); check("both_low_b", b_time, 3); check("both_low_t", tick, 0);

    reload(8'd0);
    a_stop = 1'b0; step(1); step(1);
    check("zero_load_z", a_zero, 1); check("zero_load_a", a_time, 0);
    check("zero_load_t", tick, 0); check("zero_load_bz", b_zero, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
